// File: rtl/lisnoc_na_out_arbiter.sv
// lisnoc_na_out_arbiter: packet-atomic merge of nsrc sources onto a multi-VC LISNoC link.
// Define LISNOC_NA_ARB_TIMEOUT_EN to enable per-VC stall detection on stall_err.
module lisnoc_na_out_arbiter #(
    parameter int nsrc = 4,
    parameter int vchannels = 3,
    parameter int noc_data_width = 32,
    parameter int noc_type_width = 2,
    parameter int noc_flit_width = noc_data_width + noc_type_width,
    parameter logic [4*nsrc-1:0] src_vc_map = 16'h0210,
    parameter int timeout = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [nsrc*noc_flit_width-1:0] src_flit,
    input  logic [nsrc-1:0]                src_valid,
    output logic [nsrc-1:0]                src_ready,
    output logic [noc_flit_width-1:0]      noc_out_flit,
    output logic [vchannels-1:0]           noc_out_valid,
    input  logic [vchannels-1:0]           noc_out_ready,
    output logic [vchannels-1:0]           vc_locked,
    output logic [vchannels-1:0]           stall_err
);
    localparam int sw = nsrc > 1 ? $clog2(nsrc) : 1;
    localparam int vw = vchannels > 1 ? $clog2(vchannels) : 1;
    localparam int tw = noc_type_width;
    localparam logic [tw-1:0] ty_header = tw'(1);
    localparam logic [tw-1:0] ty_last = tw'(2);
    localparam logic [tw-1:0] ty_single = tw'(3);

    function automatic int rr(input int p, input int k, input int n);
        return (p + k) % n;
    endfunction

    function automatic logic mapped(input int s, input int v);
        return int'(src_vc_map[4*s +: 4]) == v;
    endfunction

    logic [noc_flit_width-1:0] sflit [nsrc];
    logic [nsrc-1:0] start_ok;
    logic [vchannels-1:0] hold_valid, locked, pop, acc, gfound;
    logic [noc_flit_width-1:0] hold_flit [vchannels];
    logic [noc_flit_width-1:0] in_flit [vchannels];
    logic [tw-1:0] in_ty [vchannels];
    logic [sw-1:0] rr_ptr [vchannels];
    logic [sw-1:0] lock_src [vchannels];
    logic [sw-1:0] gidx [vchannels];
    logic [vw-1:0] link_ptr, ch;
    logic link_any;

    for (genvar i = 0; i < nsrc; i++) begin : g_src
        assign sflit[i] = src_flit[i*noc_flit_width +: noc_flit_width];
        assign start_ok[i] = src_valid[i] &&
            (sflit[i][noc_flit_width-1 -: tw] == ty_header || sflit[i][noc_flit_width-1 -: tw] == ty_single);
    end

    // A locked VC serves only its owner; otherwise round-robin over packet starts.
    always_comb begin
        src_ready = '0;
        for (int v = 0; v < vchannels; v++) begin
            gfound[v] = locked[v];
            gidx[v] = lock_src[v];
            for (int k = 0; k < nsrc; k++)
                if (!gfound[v] && start_ok[rr(int'(rr_ptr[v]), k, nsrc)] && mapped(rr(int'(rr_ptr[v]), k, nsrc), v)) begin
                    gfound[v] = 1'b1;
                    gidx[v] = sw'(rr(int'(rr_ptr[v]), k, nsrc));
                end
            in_flit[v] = sflit[gidx[v]];
            in_ty[v] = in_flit[v][noc_flit_width-1 -: tw];
            acc[v] = gfound[v] & src_valid[gidx[v]] & (~hold_valid[v] | pop[v]);
            if (gfound[v] & (~hold_valid[v] | pop[v])) src_ready[gidx[v]] = 1'b1;
        end
    end

    always_comb begin
        ch = '0;
        link_any = 1'b0;
        for (int k = 0; k < vchannels; k++)
            if (!link_any && hold_valid[rr(int'(link_ptr), k, vchannels)] && noc_out_ready[rr(int'(link_ptr), k, vchannels)]) begin
                link_any = 1'b1;
                ch = vw'(rr(int'(link_ptr), k, vchannels));
            end
        pop = '0;
        pop[ch] = link_any;
        noc_out_valid = pop;
        noc_out_flit = link_any ? hold_flit[ch] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= '0;
            locked <= '0;
            link_ptr <= '0;
            for (int v = 0; v < vchannels; v++) begin
                hold_flit[v] <= '0;
                rr_ptr[v] <= '0;
                lock_src[v] <= '0;
            end
        end else begin
            if (link_any) link_ptr <= vw'(rr(int'(ch), 1, vchannels));
            for (int v = 0; v < vchannels; v++) begin
                if (acc[v]) begin
                    hold_valid[v] <= 1'b1;
                    hold_flit[v] <= in_flit[v];
                end else if (pop[v]) begin
                    hold_valid[v] <= 1'b0;
                end
                if (acc[v] && !locked[v] && in_ty[v] == ty_header) begin
                    locked[v] <= 1'b1;
                    lock_src[v] <= gidx[v];
                end
                if (acc[v] && locked[v] && in_ty[v] == ty_last) locked[v] <= 1'b0;
                if (acc[v] && (locked[v] ? in_ty[v] == ty_last : in_ty[v] == ty_single))
                    rr_ptr[v] <= sw'(rr(int'(gidx[v]), 1, nsrc));
            end
        end
    end

    assign vc_locked = locked;

`ifdef LISNOC_NA_ARB_TIMEOUT_EN
    localparam int cw = $clog2(timeout + 1);
    logic [cw-1:0] stall_cnt [vchannels];

    // Counts idle cycles of the lock owner; the flag is sticky and never breaks the lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_err <= '0;
            for (int v = 0; v < vchannels; v++) stall_cnt[v] <= '0;
        end else begin
            for (int v = 0; v < vchannels; v++) begin
                if (!locked[v] || acc[v]) begin
                    stall_cnt[v] <= '0;
                end else if (!src_valid[lock_src[v]] && stall_cnt[v] != cw'(timeout)) begin
                    stall_cnt[v] <= stall_cnt[v] + 1'b1;
                    if (stall_cnt[v] == cw'(timeout - 1)) stall_err[v] <= 1'b1;
                end
            end
        end
    end
`else
    assign stall_err = '0;
`endif
endmodule

// File: tb/tb_lisnoc_na_out_arbiter.sv
// tb_lisnoc_na_out_arbiter: vector table plus scoreboarded packet sequences.
module tb_lisnoc_na_out_arbiter;
    localparam int W = 34;
    localparam logic [15:0] map = 16'h0210;
    localparam logic [1:0] PL = 2'b00, HD = 2'b01, LS = 2'b10, SG = 2'b11;

    logic clk = 1'b0;
    logic rst;
    logic [4*W-1:0] src_flit;
    logic [3:0] src_valid, src_ready;
    logic [W-1:0] noc_out_flit;
    logic [2:0] noc_out_valid, noc_out_ready, vc_locked, stall_err;

    lisnoc_na_out_arbiter #(.timeout(8)) dut (
        .clk(clk), .rst(rst), .src_flit(src_flit), .src_valid(src_valid),
        .src_ready(src_ready), .noc_out_flit(noc_out_flit), .noc_out_valid(noc_out_valid),
        .noc_out_ready(noc_out_ready), .vc_locked(vc_locked), .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [7:0] ty;
        logic [3:0] exp_rdy;
        logic [2:0] exp_out;
        logic [2:0] exp_lock;
        logic [W-1:0] exp_flit;
    } vec_t;

    vec_t vecs [8];
    logic [W-1:0] sq [4][$];
    logic [W-1:0] sb [3][$];
    int vc_log[$];
    int acc_log[$];
    int acc_cnt [4];
    int out_cnt [3];
    int last_acc [4];
    int last_out [3];
    int cyc, tests, fails;
    logic [3:0] rdy_seen;

    function automatic int vc_of(input int i);
        return int'(map[4*i +: 4]);
    endfunction

    function automatic logic [W-1:0] mk(input logic [1:0] t, input int d);
        return {t, 32'(d)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_valid = '0;
        src_flit = '0;
        noc_out_ready = 3'b111;
        for (int i = 0; i < 4; i++) sq[i].delete();
        for (int v = 0; v < 3; v++) sb[v].delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        vc_log.delete();
        acc_log.delete();
        cyc = 0;
        for (int i = 0; i < 4; i++) begin acc_cnt[i] = 0; last_acc[i] = -1; end
        for (int v = 0; v < 3; v++) begin out_cnt[v] = 0; last_out[v] = -1; end
    endtask

    task automatic step();
        for (int i = 0; i < 4; i++) begin
            src_valid[i] = sq[i].size() != 0;
            src_flit[i*W +: W] = src_valid[i] ? sq[i][0] : '0;
        end
        @(negedge clk);
        rdy_seen = src_ready;
        if (noc_out_valid != 0) begin
            chk("out_onehot", 64'($onehot(noc_out_valid)), 1);
            for (int v = 0; v < 3; v++)
                if (noc_out_valid[v]) begin
                    vc_log.push_back(v);
                    out_cnt[v]++;
                    last_out[v] = cyc;
                    if (sb[v].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_unexpected vc%0d: got flit %h, required none", v, noc_out_flit);
                    end else chk("sb_flit", noc_out_flit, sb[v].pop_front());
                end
        end
        for (int i = 0; i < 4; i++)
            if (src_valid[i] && src_ready[i]) begin
                sb[vc_of(i)].push_back(sq[i].pop_front());
                acc_log.push_back(i);
                acc_cnt[i]++;
                last_acc[i] = cyc;
            end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (n < limit && (sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size()
                              + sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
            step();
            n++;
        end
        chk(name, 64'(n < limit), 1);
    endtask

    task automatic push_pkt(input int s, input int len, input int base);
        for (int k = 0; k < len; k++)
            sq[s].push_back(mk(k == 0 ? HD : (k == len - 1 ? LS : PL), base + k));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a0, o0, o1;
        logic exp_stall;
        tests = 0;
        fails = 0;
        vecs[0] = '{4'b1001, 8'b01_00_00_01, 4'b0001, 3'b001, 3'b001, {HD, 32'hA0}};
        vecs[1] = '{4'b1001, 8'b01_00_00_00, 4'b1000, 3'b001, 3'b001, {HD, 32'hA3}};
        vecs[2] = '{4'b1111, 8'b11_11_11_11, 4'b0111, 3'b001, 3'b000, {SG, 32'hA0}};
        vecs[3] = '{4'b0010, 8'b00_00_10_00, 4'b0000, 3'b000, 3'b000, '0};
        vecs[4] = '{4'b1100, 8'b11_01_00_00, 4'b1100, 3'b001, 3'b100, {SG, 32'hA3}};
        vecs[5] = '{4'b0000, 8'b00_00_00_00, 4'b0000, 3'b000, 3'b000, '0};
        vecs[6] = '{4'b1111, 8'b00_00_00_00, 4'b0000, 3'b000, 3'b000, '0};
        vecs[7] = '{4'b0110, 8'b00_11_11_00, 4'b0110, 3'b010, 3'b000, {SG, 32'hA1}};

        do_reset();
        @(negedge clk);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_out_valid", noc_out_valid, 0);
        chk("rst_out_flit", noc_out_flit, 0);
        chk("rst_locked", vc_locked, 0);
        chk("rst_stall", stall_err, 0);

        for (int n = 0; n < 8; n++) begin
            do_reset();
            src_valid = vecs[n].valid;
            for (int i = 0; i < 4; i++) src_flit[i*W +: W] = {vecs[n].ty[2*i +: 2], 32'hA0 + i};
            @(negedge clk);
            chk($sformatf("vec%0d_src_ready", n), src_ready, vecs[n].exp_rdy);
            @(posedge clk); #1;
            src_valid = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", n), noc_out_valid, vecs[n].exp_out);
            chk($sformatf("vec%0d_locked", n), vc_locked, vecs[n].exp_lock);
            chk($sformatf("vec%0d_out_flit", n), noc_out_flit, vecs[n].exp_flit);
        end

        // single-flit latency
        do_reset();
        sq[1].push_back(34'h3_00000011);
        drain("lat_drain", 10);
        chk("lat_cycles", 64'(last_out[1] - last_acc[1]), 1);
        chk("lat_vc", 64'(vc_log.size() == 1 && vc_log[0] == 1), 1);

        // same-VC contention, then round-robin hands the next contest to src3
        do_reset();
        push_pkt(0, 4, 'h100);
        push_pkt(0, 4, 'h200);
        push_pkt(3, 4, 'h300);
        drain("cont_drain", 40);
        chk("cont_len", acc_log.size(), 12);
        for (int k = 0; k < 12 && k < acc_log.size(); k++)
            chk($sformatf("cont_order%0d", k), acc_log[k], (k >= 4 && k < 8) ? 3 : 0);

        // cross-VC interleave
        do_reset();
        push_pkt(0, 3, 'h400);
        push_pkt(1, 3, 'h500);
        push_pkt(2, 3, 'h600);
        drain("ilv_drain", 30);
        chk("ilv_len", vc_log.size(), 9);
        for (int k = 0; k < 9 && k < vc_log.size(); k++)
            chk($sformatf("ilv_vc%0d", k), vc_log[k], k % 3);

        // backpressure on VC0 while VC1 keeps flowing
        do_reset();
        push_pkt(0, 8, 'h700);
        for (int k = 0; k < 8; k++) sq[1].push_back(mk(SG, 'h800 + k));
        repeat (3) step();
        noc_out_ready = 3'b010;
        a0 = acc_cnt[0];
        o0 = out_cnt[0];
        o1 = out_cnt[1];
        for (int k = 0; k < 5; k++) begin
            step();
            if (k > 0) chk("bp_src_ready0", rdy_seen[0], 0);
        end
        chk("bp_vc0_accepts", 64'(acc_cnt[0] - a0 <= 1), 1);
        chk("bp_vc0_out", out_cnt[0] - o0, 0);
        chk("bp_vc1_out", out_cnt[1] - o1, 5);
        noc_out_ready = 3'b111;
        drain("bp_drain", 40);

        // stall timeout
`ifdef LISNOC_NA_ARB_TIMEOUT_EN
        exp_stall = 1'b1;
`else
        exp_stall = 1'b0;
`endif
        do_reset();
        sq[0].push_back(mk(HD, 'h900));
        step();
        repeat (7) step();
        chk("stall_early", stall_err, 0);
        step();
        chk("stall_locked", vc_locked[0], 1);
        chk("stall_err0", stall_err[0], exp_stall);
        sq[0].push_back(mk(LS, 'h901));
        step();
        chk("stall_unlock", vc_locked[0], 0);
        drain("stall_drain", 10);

        // reset mid-packet
        do_reset();
        push_pkt(0, 4, 'hA00);
        step();
        step();
        rst = 1'b1;
        src_valid = '0;
        sq[0].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int v = 0; v < 3; v++) sb[v].delete();
        @(negedge clk);
        chk("mid_out_valid", noc_out_valid, 0);
        chk("mid_out_flit", noc_out_flit, 0);
        chk("mid_locked", vc_locked, 0);
        chk("mid_src_ready", src_ready, 0);
        chk("mid_stall", stall_err, 0);
        @(posedge clk); #1;
        push_pkt(3, 2, 'hB00);
        step();
        chk("mid_src3_grant", rdy_seen[3], 1);
        drain("mid_drain", 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
